seq_alu: RTL and testbench

- Parametrised, handshaked successor to the execute-stage combinational ALU.
- Single-cycle ops (shift/add/sub/logic/compare) return a registered result.
- Adds iterative multi-cycle multiply and unsigned divide/remainder for the multicore datapath.
- Sits between the decode/issue stage and writeback. Accepts one operation at a time through a valid/ready handshake.

---
 rtl/seq_alu.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: valid/ready execute ALU with registered single-cycle ops and iterative multiply/divide.
// Optional macro SEQ_ALU_SIGNED_DIV_EN adds signed DIV (op 14) and REM (op 15).
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [3:0] OP_SLL   = 4'd0;
  localparam logic [3:0] OP_SRL   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
`ifdef SEQ_ALU_SIGNED_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd14;
  localparam logic [3:0] OP_REM   = 4'd15;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_DONE = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic             accept, go_busy, iter, last_iter;
  logic             is_mul_in, is_div_in, b_nz;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_dbz;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [W2-1:0]    acc_q, acc_d, acc_step;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, dbz_q, dbz_d;

  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic [WIDTH-1:0] busy_res;
  logic             busy_ovf, busy_is_mul;
  logic             upd;
  logic [WIDTH-1:0] new_res;
  logic             new_ovf, new_dbz;

`ifdef SEQ_ALU_SIGNED_DIV_EN
  logic is_sdiv_in;
  logic qneg_q, qneg_d, rneg_q, rneg_d, sovf_q, sovf_d;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    iter      = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      S_BUSY: begin
        iter      = 1'b1;
        last_iter = (cnt_q == CNTW'(1));
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Request decode; signed divide reuses the unsigned core on operand magnitudes
  always_comb begin
    b_nz      = (b != '0);
    is_mul_in = (op == OP_MUL) || (op == OP_MULHU);
    is_div_in = (op == OP_DIVU) || (op == OP_REMU);
    a_mag     = a;
    b_mag     = b;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    is_sdiv_in = (op == OP_DIV) || (op == OP_REM);
    if (is_sdiv_in && a[WIDTH-1]) a_mag = -a;
    if (is_sdiv_in && b[WIDTH-1]) b_mag = -b;
    is_div_in = is_div_in || is_sdiv_in;
`endif
    go_busy = accept && (is_mul_in || (is_div_in && b_nz));
  end

  // Single-cycle results; divide entries here are only reached with b == 0
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dbz = 1'b0;
    case (op)
      OP_SLL:  alu_res = b << a[SHW-1:0];
      OP_SRL:  alu_res = b >> a[SHW-1:0];
      OP_ADD: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_DIVU: begin alu_res = '1; alu_dbz = 1'b1; end
      OP_REMU: begin alu_res = a;  alu_dbz = 1'b1; end
`ifdef SEQ_ALU_SIGNED_DIV_EN
      OP_DIV:  begin alu_res = '1; alu_dbz = 1'b1; end
      OP_REM:  begin alu_res = a;  alu_dbz = 1'b1; end
`endif
      default: ;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on {hi, lo}
  always_comb begin
    busy_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
    mul_sum     = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mcand_q};
    div_trial   = acc_q[W2-1:WIDTH-1];
    div_diff    = div_trial - {1'b0, mcand_q};
    if (busy_is_mul) begin
      if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[W2-1:1]};
    end else begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_step = {acc_q[W2-2:0], 1'b0};
    end
  end

  // Final result selection for iterative ops
  always_comb begin
    busy_res = acc_step[WIDTH-1:0];
    busy_ovf = 1'b0;
    case (op_q)
      OP_MUL:   busy_ovf = |acc_step[W2-1:WIDTH];
      OP_MULHU: busy_res = acc_step[W2-1:WIDTH];
      OP_REMU:  busy_res = acc_step[W2-1:WIDTH];
`ifdef SEQ_ALU_SIGNED_DIV_EN
      OP_DIV: begin
        busy_res = qneg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        busy_ovf = sovf_q;
      end
      OP_REM: begin
        busy_res = rneg_q ? -acc_step[W2-1:WIDTH] : acc_step[W2-1:WIDTH];
        busy_ovf = sovf_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    upd      = 1'b0;
    new_res  = '0;
    new_ovf  = 1'b0;
    new_dbz  = 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    sovf_d = sovf_q;
`endif
    if (accept) begin
      op_d = op;
      if (go_busy) begin
        cnt_d   = CNTW'(WIDTH);
        mcand_d = is_mul_in ? a : b_mag;
        acc_d   = is_mul_in ? {WIDTH'(0), b} : {WIDTH'(0), a_mag};
`ifdef SEQ_ALU_SIGNED_DIV_EN
        qneg_d = is_sdiv_in && (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d = is_sdiv_in && a[WIDTH-1];
        sovf_d = is_sdiv_in && (a == MOST_NEG) && (b == '1);
`endif
      end else begin
        upd     = 1'b1;
        new_res = alu_res;
        new_ovf = alu_ovf;
        new_dbz = alu_dbz;
      end
    end
    if (iter) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNTW'(1);
      if (last_iter) begin
        upd     = 1'b1;
        new_res = busy_res;
        new_ovf = busy_ovf;
      end
    end
    if (upd) begin
      result_d = new_res;
      zero_d   = (new_res == '0);
      neg_d    = new_res[WIDTH-1];
      ovf_d    = new_ovf;
      dbz_d    = new_dbz;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      sovf_q   <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
`ifdef SEQ_ALU_SIGNED_DIV_EN
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      sovf_q   <= sovf_d;
`endif
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign negative    = neg_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model checked every valid cycle, plus directed literal vectors.
module tb_seq_alu;
  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
  logic         zero, negative, overflow, div_by_zero;

  always #5 CLK = ~CLK;

  seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .negative(negative), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  int n_vec = 0, n_chk = 0, n_fail = 0;
  logic         exp_armed = 1'b0;
  logic [W-1:0] e_res;
  logic         e_z, e_n, e_v, e_d;
  int           e_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference from arithmetic definitions
  function automatic void model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic v, output logic d, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    p  = 64'(av) * 64'(bv);
    r = '0; v = 1'b0; d = 1'b0; lat = 1;
    case (o)
      4'd0: r = bv << av[4:0];
      4'd1: r = bv >> av[4:0];
      4'd2: begin s = sa + sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd3: begin s = sa - sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd4: r = av & bv;
      4'd5: r = av | bv;
      4'd6: r = av ^ bv;
      4'd7: r = ~(av | bv);
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (av < bv) ? 32'd1 : 32'd0;
      4'd10: begin r = p[31:0]; v = (p[63:32] != 0); lat = W + 1; end
      4'd11: begin r = p[63:32]; lat = W + 1; end
      4'd12: if (bv == 0) begin r = '1; d = 1'b1; end else begin r = av / bv; lat = W + 1; end
      4'd13: if (bv == 0) begin r = av; d = 1'b1; end else begin r = av % bv; lat = W + 1; end
`ifdef SEQ_ALU_SIGNED_DIV_EN
      4'd14, 4'd15: begin
        if (bv == 0) begin
          r = (o == 4'd14) ? 32'hFFFF_FFFF : av;
          d = 1'b1;
        end else begin
          lat = W + 1;
          if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            r = (o == 4'd14) ? 32'h8000_0000 : 32'd0;
            v = 1'b1;
          end else begin
            r = (o == 4'd14) ? 32'(sa / sb) : 32'(sa % sb);
          end
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // Compare process: every cycle a result is presented
  always @(negedge CLK) begin
    if (!RST && out_valid) begin
      if (!exp_armed) chk("unexpected_out_valid", out_valid, 0);
      else begin
        chk("result", result, e_res);
        chk("zero", zero, e_z);
        chk("negative", negative, e_n);
        chk("overflow", overflow, e_v);
        chk("div_by_zero", div_by_zero, e_d);
        chk("in_ready_while_done", in_ready, 0);
      end
    end
  end

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input bit lit_en, input logic [W-1:0] lit_res,
                        input logic [3:0] lit_f);
    int waitc, lat;
    model(o, av, bv, e_res, e_v, e_d, e_lat);
    e_z = (e_res == 0);
    e_n = e_res[W-1];
    waitc = 0;
    while (!in_ready && waitc < 100) begin @(posedge CLK); #1; waitc++; end
    chk("in_ready_before_issue", in_ready, 1);
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    exp_armed = 1'b1;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge CLK); #1; lat++; end
    chk($sformatf("latency_op%0d", o), 64'(lat), 64'(e_lat));
    if (lit_en) begin
      chk($sformatf("lit_result_op%0d", o), result, lit_res);
      chk($sformatf("lit_flags_op%0d", o), {zero, negative, overflow, div_by_zero}, lit_f);
    end
    repeat (hold) begin @(posedge CLK); #1; end
    if (hold > 0) chk("held_out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    exp_armed = 1'b0;
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 0);
    chk("in_ready_after_take", in_ready, 1);
    n_vec++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int seen;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);

    // Abort a multiply with reset partway through
    op = 4'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge CLK); #1 in_valid = 1'b0;
    chk("mul_busy_in_ready", in_ready, 0);
    repeat (10) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin @(posedge CLK); #1; if (out_valid) seen++; end
    chk("abort_no_result", 64'(seen), 0);
    n_vec++;

    run_op(4'd2,  32'h7FFF_FFFF, 32'd1,        0, 1, 32'h8000_0000, 4'b0110);
    run_op(4'd3,  32'd5,         32'd5,        0, 1, 32'd0,         4'b1000);
    run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0, 1, 32'd0,        4'b1010);
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 0, 1, 32'd1,        4'b0000);
    run_op(4'd12, 32'd100,       32'd7,        0, 1, 32'd14,        4'b0000);
    run_op(4'd13, 32'd100,       32'd7,        0, 1, 32'd2,         4'b0000);
    run_op(4'd12, 32'd9,         32'd0,        0, 1, 32'hFFFF_FFFF, 4'b0101);
    run_op(4'd8,  32'hFFFF_FFFF, 32'd1,        5, 1, 32'd1,         4'b0000);
    run_op(4'd0,  32'd31,        32'd1,        0, 1, 32'h8000_0000, 4'b0100);
    run_op(4'd1,  32'd31,        32'h8000_0000, 0, 1, 32'd1,        4'b0000);
    run_op(4'd1,  32'h24,        32'hF0,       0, 1, 32'hF,         4'b0000);
    run_op(4'd3,  32'h8000_0000, 32'd1,        0, 1, 32'h7FFF_FFFF, 4'b0010);
    run_op(4'd4,  32'hF0F0,      32'hFF00,     0, 1, 32'hF000,      4'b0000);
    run_op(4'd5,  32'hF0F0,      32'hFF00,     0, 1, 32'hFFF0,      4'b0000);
    run_op(4'd6,  32'hF0F0,      32'hFF00,     2, 1, 32'h0FF0,      4'b0000);
    run_op(4'd7,  32'd0,         32'd0,        0, 1, 32'hFFFF_FFFF, 4'b0100);
    run_op(4'd9,  32'd1,         32'hFFFF_FFFF, 0, 1, 32'd1,        4'b0000);
    run_op(4'd8,  32'd1,         32'hFFFF_FFFF, 0, 1, 32'd0,        4'b1000);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'd1,        4'b0010);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, 32'hFFFF_FFFE, 4'b0100);
    run_op(4'd12, 32'd7,         32'd100,      0, 1, 32'd0,         4'b1000);
    run_op(4'd13, 32'hFFFF_FFFF, 32'd16,       0, 1, 32'd15,        4'b0000);
    run_op(4'd13, 32'd9,         32'd0,        0, 1, 32'd9,         4'b0001);
    run_op(4'd12, 32'hFFFF_FFFF, 32'd1,        0, 1, 32'hFFFF_FFFF, 4'b0100);
`ifdef SEQ_ALU_SIGNED_DIV_EN
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2,        0, 1, 32'hFFFF_FFFD, 4'b0100);
    run_op(4'd15, 32'hFFFF_FFF9, 32'd2,        0, 1, 32'hFFFF_FFFF, 4'b0100);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 4'b0110);
    run_op(4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0,        4'b1010);
    run_op(4'd14, 32'd5,         32'd0,        0, 1, 32'hFFFF_FFFF, 4'b0101);
    run_op(4'd14, 32'd7,         32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFD, 4'b0100);
    run_op(4'd15, 32'd7,         32'hFFFF_FFFE, 0, 1, 32'd1,        4'b0000);
`else
    run_op(4'd14, 32'd5,         32'd3,        0, 1, 32'd0,         4'b1000);
    run_op(4'd15, 32'd5,         32'd3,        0, 1, 32'd0,         4'b1000);
`endif
    for (int i = 0; i < 12; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, (i % 4 == 3) ? 32'd0 : $urandom,
             i % 3, 0, 32'd0, 4'b0000);
    end

    $display("checks made: %0d", n_chk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
